// File: rtl/fmul_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_wb_pkg
//  Description : Shared definitions for the floating-point multiplier
//                write-back stage. Contains the exception flag bit indices,
//                the precision mode encodings, the canonical NaN/Inf words
//                shared with the multiplier, the buffered entry layout, and
//                the half-precision canonicalisation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fmul_wb_pkg;

    // Bit positions inside the 5-bit exception vector
    localparam int FLG_OVF = 4;
    localparam int FLG_UNF = 3;
    localparam int FLG_INV = 2;
    localparam int FLG_INX = 1;
    localparam int FLG_DEN = 0;

    // Precision select encodings
    localparam logic MODE_HALF   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Canonical special values, shared with the multiplier datapath
    localparam logic [15:0] c_half_qnan   = 16'h7E00;
    localparam logic [15:0] c_half_inf    = 16'h7C00;
    localparam logic [31:0] c_single_qnan = 32'h7FC0_0000;
    localparam logic [31:0] c_single_inf  = 32'h7F80_0000;

    localparam int c_flag_w = 5;

    // One buffered result: canonical word, its exception flags and its mode
    typedef struct packed {
        logic [31:0]         data;
        logic [c_flag_w-1:0] flags;
        logic                mode_fp;
    } wb_entry_t;

    // Half results occupy [15:0]. The multiplier may leave the sign at [31];
    // fold it into the half sign bit and clear the upper half.
    function automatic logic [31:0] canon_result(input logic [31:0] re,
                                                 input logic        mode_fp);
        logic [31:0] res;
        if (mode_fp == MODE_SINGLE) begin
            res = re;
        end else begin
            res = {16'h0000, re[15] | re[31], re[14:0]};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_fifo
//  Description : Synchronous circular-buffer FIFO, DEPTH x WIDTH, with a
//                registered occupancy count from which full and empty are
//                derived. Pushes while full and pops while empty are ignored.
//                Storage is not reset; only pointers and count are.
//  Ports       : clk, rst_n (sync, active-low)
//                push/wdata  - write request and data
//                pop/rdata   - read request and head data (raw, unqualified)
//                full/empty  - occupancy status, registered-count based
//  Revision    : 1.0  initial release
// ============================================================================
module fp_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmul_wb.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_wb
//  Description : Write-back stage behind the combinational FP multiplier.
//                Canonicalises half results, buffers results in a FIFO,
//                keeps sticky exception flags, a saturating op counter and
//                a maskable exception interrupt.
//  Ports       : clk, rst_n (sync, active-low)
//                in_valid/in_ready, in_re, in_flags, in_mode_fp - upstream
//                out_valid/out_ready, out_data, out_flags, out_mode_fp
//                sticky_flags, flags_clr, exc_mask, exc_irq, op_count
//  Revision    : 1.0  initial release
// ============================================================================
module fmul_wb
    import fmul_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_re,
    input  logic [4:0]       in_flags,
    input  logic             in_mode_fp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_flags,
    output logic             out_mode_fp,
    output logic [4:0]       sticky_flags,
    input  logic             flags_clr,
    input  logic [4:0]       exc_mask,
    output logic             exc_irq,
    output logic [CNT_W-1:0] op_count
);

    localparam int ENTRY_W = $bits(wb_entry_t);

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    wb_entry_t       w_wr_entry;
    wb_entry_t       w_rd_entry;
    logic [4:0]      w_push_flags;
    logic [4:0]      r_sticky;
    logic [CNT_W-1:0] r_op_count;

    // No bypass: a full buffer refuses input even if it drains this cycle
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_ready && !w_empty;

    assign w_wr_entry.data    = canon_result(in_re, in_mode_fp);
    assign w_wr_entry.flags   = in_flags;
    assign w_wr_entry.mode_fp = in_mode_fp;

    fp_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_wr_entry),
        .pop   (w_pop),
        .rdata (w_rd_entry),
        .full  (w_full),
        .empty (w_empty)
    );

    // Unused storage may hold stale data; present zeros when nothing is valid
    assign out_data    = w_empty ? 32'h0 : w_rd_entry.data;
    assign out_flags   = w_empty ? 5'h0  : w_rd_entry.flags;
    assign out_mode_fp = w_empty ? 1'b0  : w_rd_entry.mode_fp;

    assign w_push_flags = w_push ? in_flags : 5'h0;

    // Clear takes effect first, so a push in the clearing cycle still counts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (flags_clr) begin
            r_sticky <= w_push_flags;
        end else begin
            r_sticky <= r_sticky | w_push_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (flags_clr) begin
            r_op_count <= w_push ? CNT_W'(1) : '0;
        end else if (w_push && (r_op_count != {CNT_W{1'b1}})) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign sticky_flags = r_sticky;
    assign op_count     = r_op_count;
    assign exc_irq      = |(r_sticky & exc_mask);

endmodule
`default_nettype wire

// File: tb/tb_fmul_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmul_wb
//  Description : Self-checking bench for fmul_wb. A reference model keeps a
//                queue of expected entries plus sticky/count state; every
//                cycle all outputs are compared against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fmul_wb;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_re;
    logic [4:0]       in_flags;
    logic             in_mode_fp;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [4:0]       out_flags;
    logic             out_mode_fp;
    logic [4:0]       sticky_flags;
    logic             flags_clr;
    logic [4:0]       exc_mask;
    logic             exc_irq;
    logic [CNT_W-1:0] op_count;

    fmul_wb #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_re        (in_re),
        .in_flags     (in_flags),
        .in_mode_fp   (in_mode_fp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .out_mode_fp  (out_mode_fp),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr),
        .exc_mask     (exc_mask),
        .exc_irq      (exc_irq),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [37:0]      m_q [$];
    logic [4:0]       m_sticky;
    logic [CNT_W-1:0] m_cnt;
    logic             m_pushed;
    int               n_tests;
    int               n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_canon(input logic [31:0] re, input logic mode);
        logic [31:0] r;
        if (mode) r = re;
        else      r = {16'h0000, re[15] | re[31], re[14:0]};
        return r;
    endfunction

    // Inputs are already driven (just after a falling edge). Compare all
    // outputs with the model, advance the model across the next rising edge,
    // then return just after the following falling edge.
    task automatic step();
        logic        exp_valid;
        logic        exp_ready;
        logic [37:0] head;
        logic        push;
        logic        pop;
        #1;
        exp_valid = (m_q.size() != 0);
        exp_ready = (m_q.size() < DEPTH);
        head      = exp_valid ? m_q[0] : 38'h0;
        chk("in_ready",     {63'h0, in_ready},     {63'h0, exp_ready});
        chk("out_valid",    {63'h0, out_valid},    {63'h0, exp_valid});
        chk("out_data",     {32'h0, out_data},     {32'h0, head[37:6]});
        chk("out_flags",    {59'h0, out_flags},    {59'h0, head[5:1]});
        chk("out_mode_fp",  {63'h0, out_mode_fp},  {63'h0, head[0]});
        chk("sticky_flags", {59'h0, sticky_flags}, {59'h0, m_sticky});
        chk("op_count",     {48'h0, op_count},     {48'h0, m_cnt});
        chk("exc_irq",      {63'h0, exc_irq},      {63'h0, |(m_sticky & exc_mask)});
        push = in_valid && exp_ready;
        pop  = out_ready && exp_valid;
        m_pushed = rst_n && push;
        if (!rst_n) begin
            m_q.delete();
            m_sticky = '0;
            m_cnt    = '0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({ref_canon(in_re, in_mode_fp), in_flags, in_mode_fp});
            if (flags_clr) begin
                m_sticky = push ? in_flags : 5'h0;
                m_cnt    = push ? 16'd1 : 16'd0;
            end else begin
                if (push) m_sticky = m_sticky | in_flags;
                if (push && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] re, input logic [4:0] f, input logic mode);
        in_valid   = v;
        in_re      = re;
        in_flags   = f;
        in_mode_fp = mode;
    endtask

    initial begin
        int k;
        n_tests   = 0;
        n_fail    = 0;
        m_sticky  = '0;
        m_cnt     = '0;
        m_pushed  = 1'b0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        exc_mask  = 5'h00;
        drive(1'b0, 32'h0, 5'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'h0, in_ready},  64'd1);
        chk("rst_out_data",  {32'h0, out_data},  64'd0);
        chk("rst_op_count",  {48'h0, op_count},  64'd0);
        chk("rst_exc_irq",   {63'h0, exc_irq},   64'd0);
        rst_n = 1'b1;
        step();

        // Single-precision push, consumer stalled
        drive(1'b1, 32'h3FC0_0000, 5'b00000, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'h0, 1'b0);
        #1;
        chk("single_valid", {63'h0, out_valid}, 64'd1);
        chk("single_data",  {32'h0, out_data},  64'h3FC0_0000);
        chk("single_cnt",   {48'h0, op_count},  64'd1);
        step();

        // Half push with misplaced sign; drain the single at the same time
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 5'b00001, 1'b0);
        step();
        drive(1'b0, 32'h0, 5'h0, 1'b0);
        #1;
        chk("half_data",   {32'h0, out_data},     64'h0000_8000);
        chk("half_sticky", {59'h0, sticky_flags}, 64'h01);
        step();

        // Fill to full, extra request refused, then pop while full
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA000_0000 + k, 5'(k), 1'b1);
            step();
            if (m_pushed) k++;
        end
        #1;
        chk("full_in_ready", {63'h0, in_ready}, 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'hA000_0000 + k, 5'(k), 1'b1);
        step();
        chk("full_pop_nopush", {63'h0, m_pushed}, 64'd0);
        // Keep streaming with an irregular consumer until 10 entries crossed
        for (int i = 0; i < 40 && k < 10; i++) begin
            out_ready = ((i % 3) != 1);
            drive(1'b1, 32'hA000_0000 + k, 5'(k), k[0]);
            step();
            if (m_pushed) k++;
        end
        drive(1'b0, 32'h0, 5'h0, 1'b0);
        out_ready = 1'b1;
        repeat (DEPTH + 1) step();

        // Sticky clear-then-set ordering and interrupt masking
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        drive(1'b1, 32'h3F80_0000, 5'b00100, 1'b1);
        step();
        flags_clr = 1'b1;
        drive(1'b1, 32'h4000_0000, 5'b10010, 1'b1);
        step();
        flags_clr = 1'b0;
        drive(1'b0, 32'h0, 5'h0, 1'b0);
        exc_mask = 5'b10000;
        #1;
        chk("clr_sticky", {59'h0, sticky_flags}, 64'h12);
        chk("clr_cnt",    {48'h0, op_count},     64'd1);
        chk("irq_on",     {63'h0, exc_irq},      64'd1);
        step();
        exc_mask = 5'b00000;
        #1;
        chk("irq_off", {63'h0, exc_irq}, 64'd0);
        step();

        // Counter saturation
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 32'(i), 5'h0, 1'b1);
            step();
        end
        #1;
        chk("sat_reach", {48'h0, op_count}, 64'hFFFF);
        drive(1'b1, 32'h1234_5678, 5'h0, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'h0, 1'b0);
        #1;
        chk("sat_hold", {48'h0, op_count}, 64'hFFFF);
        repeat (DEPTH + 1) step();

        // Reset with entries in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC000_0000 + i, 5'h1F, 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 5'h0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid",  {63'h0, out_valid},    64'd0);
        chk("mid_rst_data",   {32'h0, out_data},     64'd0);
        chk("mid_rst_ready",  {63'h0, in_ready},     64'd1);
        chk("mid_rst_sticky", {59'h0, sticky_flags}, 64'd0);
        chk("mid_rst_cnt",    {48'h0, op_count},     64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
